run_dump_ctrl: RTL and testbench
================================

Name: run_dump_ctrl

Overview:
- Run controller and register-dump streamer that sits directly downstream of full_machine.
- Releases the core from reset on start and counts execution cycles.
- Stops the run on exception, cycle limit or (optionally) a halt loop, then snapshots the debug register file.
- Streams the 32 captured registers out one per beat over a valid/ready port, replacing behavioural end-of-simulation dump logic with synthesizable hardware.

Parameters:
- NREGS, 32, number of registers captured and streamed.
- XLEN, 64, register width in bits.
- MAX_CYCLES, 60, RUN-cycle limit; legal range 1..2^32-1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  begin a run; sampled only in IDLE and DONE.
- except  in  1  exception flag from the core.
- pc  in  XLEN  current core PC.
- reg_in  in  NREGS x XLEN (packed [NREGS-1:0][XLEN-1:0])  debug register file from the core.
- core_reset  out  1  active-high reset to the core.
- dump_valid  out  1  dump beat valid.
- dump_ready  in  1  consumer ready.
- dump_idx  out  5  register index of the current beat.
- dump_data  out  XLEN  register value of the current beat.
- dump_last  out  1  high on beat NREGS-1.
- done  out  1  run and dump complete.
- cause  out  2  stop cause: 0 none, 1 timeout, 2 exception, 3 halt loop.
- cycle_count  out  32  number of RUN cycles executed.

Behaviour:
- Reset values (reset low, asynchronous, any state): state IDLE, core_reset=1, dump_valid=0, dump_idx=0, dump_data=0, dump_last=0, done=0, cause=0, cycle_count=0, snapshot cleared.
- States: IDLE, HOLD, RUN, DUMP, DONE.
- IDLE: core_reset=1. start=1 -> HOLD.
- HOLD: exactly 1 cycle with core_reset=1. Clears cycle_count, cause and done -> RUN.
- RUN:
  - core_reset=0. cycle_count increments by 1 on every RUN edge.
  - Stop condition on an edge, in priority order:
    - except=1 -> cause=2.
    - Halt loop detected (optional feature) -> cause=3.
    - cycle_count+1 == MAX_CYCLES -> cause=1.
  - The increment on the stopping edge is included in cycle_count.
  - On the stopping edge: snapshot all NREGS registers from reg_in; set core_reset=1 on the next cycle; go to DUMP with dump_idx=0.
  - except together with timeout on the same edge -> cause=2.
- DUMP:
  - dump_valid=1. dump_data = snapshot[dump_idx]. dump_last = (dump_idx == NREGS-1).
  - A beat transfers on an edge where dump_valid & dump_ready.
  - While dump_ready=0, dump_idx, dump_data and dump_last hold stable.
  - Transfer with dump_last=0 -> dump_idx+1.
  - Transfer with dump_last=1 -> DONE, dump_valid=0.
  - Zero-wait back-to-back streaming: one beat per cycle when dump_ready stays high.
- DONE:
  - done=1, core_reset=1; cycle_count and cause held.
  - start=1 -> HOLD (re-run); done drops in HOLD.
- start in HOLD, RUN or DUMP is ignored.
- except outside RUN is ignored.
- Snapshot, cycle_count and cause are unaffected by the core after capture.
- reset asserted mid-RUN or mid-DUMP aborts immediately to the reset values; no partial dump completes.
- cycle_count never wraps, because RUN ends at MAX_CYCLES.

Optional Feature:
- Macro: RUN_DUMP_HALT_DETECT_EN.
- Defined:
  - A pc register samples pc on every RUN cycle.
  - From the second RUN cycle onward, pc equal to the previous sample (self-jump idle loop) stops the run with cause=3.
  - Priority is below except and above timeout.
- Not defined:
  - No pc compare logic; pc port is present but unused.
  - cause=3 is never produced.

Test Plan:
- MAX_CYCLES=60, except held 0, dump_ready=1, start pulsed in IDLE -> core_reset low for exactly 60 cycles; cycle_count=60, cause=1; 32 consecutive beats with dump_idx 0..31, dump_last only on idx 31; done=1 the cycle after the last beat.
- except asserted on the 10th RUN cycle, with reg_in[5]=0x0000_0000_DEAD_BEEF at that edge -> cause=2, cycle_count=10; beat 5 carries 0xDEADBEEF even if reg_in changes afterward.
- except asserted on the same edge as timeout (MAX_CYCLES=8, except on cycle 8) -> cause=2, cycle_count=8.
- dump_ready toggled 1,0,0,1 repeatedly during DUMP -> dump_idx, dump_data and dump_last stable while stalled; exactly 32 transfers, no skipped or duplicated index.
- reset driven low mid-DUMP at beat 12 -> all outputs at reset values immediately (asynchronous); after release, start reruns from HOLD with cycle_count restarting from 0.
- With RUN_DUMP_HALT_DETECT_EN: pc sequence 0x0,0x4,0x8,0x8 -> cause=3, cycle_count=4. Without the macro, the same sequence runs until the MAX_CYCLES timeout.

Source files
------------

// File: rtl/run_dump_ctrl.sv
// run_dump_ctrl: releases the core, counts RUN cycles, stops on exception/limit/halt loop, streams a register snapshot.
// Optional halt-loop stop enabled by defining RUN_DUMP_HALT_DETECT_EN.
module run_dump_ctrl #(
    parameter int NREGS      = 32,
    parameter int XLEN       = 64,
    parameter int MAX_CYCLES = 60
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           except,
    input  logic [XLEN-1:0]                pc,
    input  logic [NREGS-1:0][XLEN-1:0]     reg_in,
    output logic                           core_reset,
    output logic                           dump_valid,
    input  logic                           dump_ready,
    output logic [$clog2(NREGS)-1:0]       dump_idx,
    output logic [XLEN-1:0]                dump_data,
    output logic                           dump_last,
    output logic                           done,
    output logic [1:0]                     cause,
    output logic [31:0]                    cycle_count
);
    localparam int IW = $clog2(NREGS);
    localparam logic [31:0] MAXC = 32'(MAX_CYCLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NREGS - 1);

    typedef enum logic [2:0] {IDLE, HOLD, RUN, DUMP, DONE} state_t;

    state_t state_q, state_d;
    logic [NREGS-1:0][XLEN-1:0] snap;
    logic halt, timeout, stop, xfer;

`ifdef RUN_DUMP_HALT_DETECT_EN
    logic [XLEN-1:0] prev_pc;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) prev_pc <= '0;
        else if (state_q == RUN) prev_pc <= pc;
    end
    // cycle_count is cleared in HOLD, so non-zero marks the second RUN cycle onward
    assign halt = (state_q == RUN) && (cycle_count != 32'd0) && (pc == prev_pc);
`else
    logic unused_pc;
    assign unused_pc = ^pc;
    assign halt = 1'b0;
`endif

    assign timeout    = (cycle_count + 32'd1) == MAXC;
    assign stop       = except | halt | timeout;
    assign core_reset = state_q != RUN;
    assign dump_valid = state_q == DUMP;
    assign dump_last  = dump_valid && (dump_idx == LAST_IDX);
    assign dump_data  = snap[dump_idx];
    assign done       = state_q == DONE;
    assign xfer       = dump_valid & dump_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = start ? HOLD : state_q;
            HOLD:       state_d = RUN;
            RUN:        state_d = stop ? DUMP : RUN;
            DUMP:       state_d = (xfer && dump_last) ? DONE : DUMP;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            snap        <= '0;
            dump_idx    <= '0;
            cause       <= 2'd0;
            cycle_count <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == HOLD) begin
                cycle_count <= 32'd0;
                cause       <= 2'd0;
            end
            if (state_q == RUN) begin
                cycle_count <= cycle_count + 32'd1;
                if (stop) begin
                    cause    <= except ? 2'd2 : halt ? 2'd3 : 2'd1;
                    snap     <= reg_in;
                    dump_idx <= '0;
                end
            end
            if (xfer) dump_idx <= dump_last ? '0 : dump_idx + IW'(1);
        end
    end
endmodule

// File: tb/tb_run_dump_ctrl.sv
// tb_run_dump_ctrl: directed self-checking bench for run_dump_ctrl (MAX_CYCLES=60).
module tb_run_dump_ctrl;
    logic clock = 0, reset = 0, start = 0, except = 0, dump_ready = 1;
    logic [63:0] pc = '0;
    logic [31:0][63:0] reg_in;
    logic core_reset, dump_valid, dump_last, done;
    logic [4:0] dump_idx;
    logic [63:0] dump_data;
    logic [1:0] cause;
    logic [31:0] cycle_count;
    logic [63:0] exp_snap [32];
    int passed = 0, total = 0;
    int n, beats, bad;

    run_dump_ctrl #(.NREGS(32), .XLEN(64), .MAX_CYCLES(60)) dut (
        .clock(clock), .reset(reset), .start(start), .except(except), .pc(pc),
        .reg_in(reg_in), .core_reset(core_reset), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
        .dump_last(dump_last), .done(done), .cause(cause), .cycle_count(cycle_count)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, expv);
    endtask

    // Pulse start, pass HOLD, then run until core_reset returns high; except fires on RUN cycle ex_at.
    task automatic run(input int ex_at, input bit halt_seq, output int cnt);
        cnt = 0;
        start = 1;
        tick;
        start = 0;
        check("hold_core_reset", core_reset, 1);
        check("hold_done", done, 0);
        tick;
        check("run_count_start", cycle_count, 0);
        while (core_reset === 1'b0 && cnt < 200) begin
            pc = halt_seq ? (cnt < 3 ? 64'(cnt * 4) : 64'h8) : 64'(256 + 4 * cnt);
            except = (cnt + 1 == ex_at);
            if (except) reg_in[5] = 64'h0000_0000_DEAD_BEEF;
            tick;
            cnt++;
        end
        except = 0;
        for (int i = 0; i < 32; i++) exp_snap[i] = reg_in[i];
        reg_in = ~reg_in;
    endtask

    // Consume beats; stall pattern is ready 1,0,0,1 repeating. stop_at limits transfers.
    task automatic dump(input bit stall, input int stop_at, output int nb, output int nbad);
        int e = 0;
        nb = 0;
        nbad = 0;
        for (int k = 0; k < 200 && dump_valid === 1'b1 && nb < stop_at; k++) begin
            dump_ready = stall ? (k % 4 == 0 || k % 4 == 3) : 1'b1;
            if (dump_idx !== 5'(e) || dump_last !== (e == 31) || dump_data !== exp_snap[e]) nbad++;
            tick;
            if (dump_ready) begin
                nb++;
                e++;
            end
        end
        dump_ready = 1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) reg_in[i] = {32'(i), 32'hA5A5_0000 + 32'(i)};
        #2;
        check("rst_core_reset", core_reset, 1);
        check("rst_valid", dump_valid, 0);
        check("rst_done", done, 0);
        check("rst_cause", cause, 0);
        check("rst_count", cycle_count, 0);
        check("rst_data", dump_data, 0);
        check("rst_last", dump_last, 0);
        check("rst_idx", dump_idx, 0);
        reset = 1;
        tick;
        tick;
        check("idle_core_reset", core_reset, 1);

        // timeout run with zero-wait streaming
        run(0, 0, n);
        check("to_run_len", n, 60);
        check("to_count", cycle_count, 60);
        check("to_cause", cause, 1);
        check("to_valid", dump_valid, 1);
        dump(0, 32, beats, bad);
        check("to_beats", beats, 32);
        check("to_bad", bad, 0);
        check("to_done", done, 1);
        check("to_valid_off", dump_valid, 0);
        except = 1;
        tick;
        tick;
        except = 0;
        check("except_ignored_cause", cause, 1);
        check("done_hold_count", cycle_count, 60);

        // exception on RUN cycle 10, snapshot must ignore later reg_in changes
        run(10, 0, n);
        check("ex_run_len", n, 10);
        check("ex_count", cycle_count, 10);
        check("ex_cause", cause, 2);
        check("ex_snap5", exp_snap[5], 64'h0000_0000_DEAD_BEEF);
        dump(1, 32, beats, bad);
        check("ex_stall_beats", beats, 32);
        check("ex_stall_bad", bad, 0);
        check("ex_done", done, 1);

        // exception on the same edge as timeout
        run(60, 0, n);
        check("both_count", cycle_count, 60);
        check("both_cause", cause, 2);
        dump(0, 32, beats, bad);
        check("both_bad", bad, 0);

        // halt-loop pc sequence 0,4,8,8
        run(0, 1, n);
`ifdef RUN_DUMP_HALT_DETECT_EN
        check("halt_count", cycle_count, 4);
        check("halt_cause", cause, 3);
`else
        check("halt_count", cycle_count, 60);
        check("halt_cause", cause, 1);
`endif
        dump(0, 12, beats, bad);
        check("mid_beats", beats, 12);
        check("mid_idx", dump_idx, 12);
        #2 reset = 0;
        #1;
        check("arst_valid", dump_valid, 0);
        check("arst_core_reset", core_reset, 1);
        check("arst_idx", dump_idx, 0);
        check("arst_data", dump_data, 0);
        check("arst_count", cycle_count, 0);
        check("arst_cause", cause, 0);
        check("arst_done", done, 0);
        reset = 1;
        tick;
        check("post_rst_idle", core_reset, 1);
        run(0, 0, n);
        check("rerun_len", n, 60);
        check("rerun_cause", cause, 1);
        dump(0, 32, beats, bad);
        check("rerun_beats", beats, 32);
        check("rerun_bad", bad, 0);
        check("rerun_done", done, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
